// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment check used when a request is accepted.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  // Illegal size counts as an error, just like a misaligned half/word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic res;
    res = 1'b1;
    case (size)
      SIZE_BYTE: res = 1'b0;
      SIZE_HALF: res = lane[0];
      SIZE_WORD: res = |lane;
      SIZE_ILL:  res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends load data from a RAM word,
// and merges a sub-word store into the old word for read-modify-write.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

    ldata_o = word_i;
    case (size_i)
      SIZE_BYTE: ldata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: ldata_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   ldata_o = word_i;
    endcase

    merged_o = word_i;
    case (size_i)
      SIZE_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SIZE_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:   merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit in front of a word-wide synchronous RAM: one request at a time,
// sub-word stores by read-modify-write, loads extended before the response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_t          state_q, state_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            accept;
  logic            req_bad;
  logic [DW-1:0]   ldata;
  logic [DW-1:0]   merged;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid && (state_q == ST_IDLE);
  assign req_bad     = misaligned(req_size, req_addr[1:0]);

  mem_lane_align u_align (
    .word_i   (mem_dout),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .sign_i   (sgn_q),
    .wdata_i  (wdata_q),
    .ldata_o  (ldata),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr[AW+1:0];
          rdata_d = '0;
          err_d   = req_bad;
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          if (req_bad)                     state_d = ST_DONE;
          else if (req_we && req_size == SIZE_WORD) state_d = ST_WR;
          else                             state_d = ST_RD;
        end
      end
      ST_RD:  state_d = ST_CAP;
      // mem_dout is valid here; loads finish, sub-word stores merge and write back
      ST_CAP: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = ST_WR;
        end else begin
          rdata_d = ldata;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    wdata_q <= wdata_d;
  end

  // Port drive is decoded from state so a reset kills a pending write at once.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = (state_q == ST_DONE) && err_q;
  assign rsp_rdata = rdata_q;
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = addr_q[AW+1:2];
  assign mem_din   = (state_q == ST_WR) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a behavioural RAM image as reference.
module tb_mem_access_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_chk = 0;
  int n_fail = 0;

  mem_access_ctrl #(.AW(AW), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the DUT
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lane);
    logic [31:0] v;
    v = w >> (8 * lane);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (old & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd);
    logic [9:0]  wi;
    logic        e;
    logic [31:0] exp_rd, exp_word;
    int          exp_lat, lat, wecnt;
    bit          seen;
    wi       = a[11:2];
    e        = is_err(sz, a);
    exp_word = ref_mem[wi];
    exp_rd   = '0;
    if (e)        exp_lat = 1;
    else if (!we) begin exp_lat = 3; exp_rd = load_val(ref_mem[wi], sz, sg, a[1:0]); end
    else begin
      exp_lat  = (sz == 2'd2) ? 2 : 4;
      exp_word = store_val(ref_mem[wi], sz, a[1:0], wd);
    end

    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    lat = 0; wecnt = 0; seen = 1'b0; rd = '0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (hold) begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      if (mem_we) begin
        wecnt++;
        chk("mem_din", mem_din, exp_word);
      end else begin
        chk("din_zero", mem_din, 32'd0);
      end
      if (rsp_valid) begin
        seen = 1'b1; lat = c; rd = rsp_rdata;
        req_valid = 1'b0;
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end else begin
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        if (!e) chk("mem_addr", {22'd0, mem_addr}, {22'd0, wi});
      end
    end
    chk("rsp_lat", lat, exp_lat);
    chk("we_cnt", wecnt, (we && !e) ? 32'd1 : 32'd0);
    if (we && !e) ref_mem[wi] = exp_word;
    @(negedge clk);
    chk("rsp_once", {31'd0, rsp_valid}, 32'd0);
    chk("ram_word", ram[wi], ref_mem[wi]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, a, old;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Initialise the 16-word working region through the DUT
    for (int w = 0; w < 16; w++) begin
      a = ($urandom & 32'hFFFF_F000) | (w << 2);
      do_req(1'b1, 2'd2, 1'b0, a, $urandom, 1'b0, rd);
    end

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, rd);
    chk("lb_0x10", rd, 32'hFFFF_FFEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, rd);
    chk("lbu_0x13", rd, 32'h0000_00DE);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 1'b0, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("lw_after_sh", rd, 32'h1234_BEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055, 1'b0, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("lw_after_sb", rd, 32'h1234_55EF);
    do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b0, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0, rd);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b0, rd);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, rd);
    chk("lh_hold", rd, 32'h0000_1234);
    do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_F012, 32'h0000_8001, 1'b1, rd);

    for (int i = 0; i < 200; i++) begin
      a = ($urandom & 32'hFFFF_F000) | ($urandom & 32'h3F);
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             ($urandom_range(0, 3) == 0), rd);
    end

    // Reset while the write-back of a byte store is pending
    old = ref_mem[4];
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 6 && !mem_we; c++) @(negedge clk);
    chk("rst_we_seen", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we_drop", {31'd0, mem_we}, 32'd0);
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ram_kept", ram[4], old);
    chk("rst_idle", {31'd0, req_ready}, 32'd1);
    chk("rst_addr_clr", {22'd0, mem_addr}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_quiet", {30'd0, rsp_valid, mem_we}, 32'd0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("lw_after_rst", rd, old);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
